// File: rtl/arith_order_sched.sv
// Arithmetic-unit order sequencer: accepts one decoded order, stimulates the selected
// panel on an odd minor cycle, waits for its end pulse and reports back with a watchdog.
// Optional sign-questioning step for add-class orders: define ARITH_SCHED_SIGN_QUERY_EN.
module arith_order_sched #(
   parameter int CNT_W         = 6,
   parameter int TIMEOUT_MINOR = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             order_valid,
   input  logic [2:0]       order_class,
   input  logic             r2,
   input  logic             g8,
   input  logic             ev_d0,
   input  logic             odd_d0,
   input  logic             ep_add,
   input  logic             ep_mul,
   input  logic             ep_shift,
`ifdef ARITH_SCHED_SIGN_QUERY_EN
   input  logic             sign_r,
   output logic             sign_q,
`endif
   output logic             busy,
   output logic [2:0]       stim,
   output logic [2:0]       gate,
   output logic             ep_out,
   output logic             err_illegal,
   output logic             err_timeout,
   output logic [CNT_W-1:0] minor_cnt
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_SYNC  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
   localparam logic [2:0] S_SIGNQ = 3'd5;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT_MINOR);

   logic [2:0]       state_q, state_d;
   logic [2:0]       cls_q, cls_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [2:0]       stim_q, stim_d;
   logic [2:0]       gate_q, gate_d;
   logic             ep_out_q, ep_out_d;
   logic             err_illegal_q, err_illegal_d;
   logic             err_timeout_q, err_timeout_d;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
   logic             sign_q_q, sign_q_d;
`endif

   logic             class_onehot;
   logic             ep_match;
   logic             gate_state;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] cnt_run;
   logic             timeout_hit;

   always_comb begin
      class_onehot = (order_class == 3'b001) || (order_class == 3'b010) ||
                     (order_class == 3'b100);
      ep_match     = |(cls_q & {ep_shift, ep_mul, ep_add});
      cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
      cnt_run      = ev_d0 ? cnt_inc : cnt_q;
      // the abort fires in the cycle the count reaches the limit, unless the panel ends too
      timeout_hit  = (cnt_run == TMO);

      state_d       = state_q;
      cls_d         = cls_q;
      cnt_d         = cnt_q;
      err_illegal_d = 1'b0;
      err_timeout_d = 1'b0;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
      sign_q_d      = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (order_valid) begin
               if (class_onehot) begin
                  cls_d   = order_class;
                  state_d = S_ARMED;
               end else begin
                  err_illegal_d = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARMED: begin
            if (r2 && !g8) begin
               state_d = S_SYNC;
            end else begin
               state_d = S_ARMED;
            end
         end
         S_SYNC: begin
            if (odd_d0 && !g8) begin
               state_d = S_RUN;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = S_SYNC;
            end
         end
         S_RUN: begin
            cnt_d = cnt_run;
            if (ep_match) begin
`ifdef ARITH_SCHED_SIGN_QUERY_EN
               if (cls_q[0]) begin
                  state_d  = S_SIGNQ;
                  sign_q_d = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
`else
               state_d = S_DONE;
`endif
            end else if (timeout_hit) begin
               state_d       = S_IDLE;
               err_timeout_d = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
`ifdef ARITH_SCHED_SIGN_QUERY_EN
         S_SIGNQ: begin
            cnt_d = cnt_run;
            if (sign_r) begin
               state_d = S_DONE;
            end else if (timeout_hit) begin
               state_d       = S_IDLE;
               err_timeout_d = 1'b1;
            end else begin
               state_d = S_SIGNQ;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

`ifdef ARITH_SCHED_SIGN_QUERY_EN
      gate_state = (state_d == S_RUN) || (state_d == S_SIGNQ);
`else
      gate_state = (state_d == S_RUN);
`endif
      busy_d   = (state_d != S_IDLE);
      stim_d   = ((state_q == S_SYNC) && (state_d == S_RUN)) ? cls_q : 3'b000;
      gate_d   = gate_state ? cls_q : 3'b000;
      ep_out_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cls_q         <= 3'b000;
         cnt_q         <= {CNT_W{1'b0}};
         busy_q        <= 1'b0;
         stim_q        <= 3'b000;
         gate_q        <= 3'b000;
         ep_out_q      <= 1'b0;
         err_illegal_q <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
         sign_q_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cls_q         <= cls_d;
         cnt_q         <= cnt_d;
         busy_q        <= busy_d;
         stim_q        <= stim_d;
         gate_q        <= gate_d;
         ep_out_q      <= ep_out_d;
         err_illegal_q <= err_illegal_d;
         err_timeout_q <= err_timeout_d;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
         sign_q_q      <= sign_q_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign stim        = stim_q;
   assign gate        = gate_q;
   assign ep_out      = ep_out_q;
   assign err_illegal = err_illegal_q;
   assign err_timeout = err_timeout_q;
   assign minor_cnt   = cnt_q;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
   assign sign_q      = sign_q_q;
`endif

endmodule

// File: tb/tb_arith_order_sched.sv
// Scoreboard bench for arith_order_sched: directed orders push expected output snapshots,
// a negedge monitor pops and compares whenever the DUT pulses stim/ep_out/err_*.
module tb_arith_order_sched;

   localparam int CNT_W = 6;
   localparam int TMO   = 4;

   localparam logic [6:0] P_R2  = 7'b1000000;
   localparam logic [6:0] P_EV  = 7'b0100000;
   localparam logic [6:0] P_ODD = 7'b0010000;
   localparam logic [6:0] P_ADD = 7'b0001000;
   localparam logic [6:0] P_MUL = 7'b0000100;
   localparam logic [6:0] P_SH  = 7'b0000010;
   localparam logic [6:0] P_OV  = 7'b0000001;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             order_valid = 1'b0;
   logic [2:0]       order_class = 3'b000;
   logic             r2 = 1'b0, g8 = 1'b0, ev_d0 = 1'b0, odd_d0 = 1'b0;
   logic             ep_add = 1'b0, ep_mul = 1'b0, ep_shift = 1'b0;
   logic             busy, ep_out, err_illegal, err_timeout;
   logic [2:0]       stim, gate;
   logic [CNT_W-1:0] minor_cnt;
`ifdef ARITH_SCHED_SIGN_QUERY_EN
   logic             sign_r = 1'b0;
   logic             sign_q;
`endif

   typedef struct {
      string       name;
      logic [15:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   arith_order_sched #(.CNT_W(CNT_W), .TIMEOUT_MINOR(TMO)) dut (
      .clk(clk), .rst(rst), .order_valid(order_valid), .order_class(order_class),
      .r2(r2), .g8(g8), .ev_d0(ev_d0), .odd_d0(odd_d0),
      .ep_add(ep_add), .ep_mul(ep_mul), .ep_shift(ep_shift),
`ifdef ARITH_SCHED_SIGN_QUERY_EN
      .sign_r(sign_r), .sign_q(sign_q),
`endif
      .busy(busy), .stim(stim), .gate(gate), .ep_out(ep_out),
      .err_illegal(err_illegal), .err_timeout(err_timeout), .minor_cnt(minor_cnt)
   );

   always #5 clk = ~clk;

   // snapshot layout: stim[15:13] gate[12:10] ep_out[9] ill[8] to[7] busy[6] cnt[5:0]
   function automatic logic [15:0] mk(input logic [2:0] s, input logic [2:0] g, input logic ep,
                                      input logic ill, input logic to, input logic b,
                                      input logic [5:0] c);
      return {s, g, ep, ill, to, b, c};
   endfunction

   function automatic logic [15:0] snap();
      return {stim, gate, ep_out, err_illegal, err_timeout, busy, minor_cnt};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic pulse(input logic [6:0] p);
      {r2, ev_d0, odd_d0, ep_add, ep_mul, ep_shift, order_valid} = p;
      cyc();
      {r2, ev_d0, odd_d0, ep_add, ep_mul, ep_shift, order_valid} = 7'b0000000;
   endtask

   task automatic expect_ev(input string n, input logic [15:0] v);
      exp_t e;
      e.name = n;
      e.v    = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", n, act, exp);
   endtask

   task automatic start(input logic [2:0] c, input string n);
      order_class = c;
      pulse(P_OV);
      pulse(P_R2);
      expect_ev({n, "_stim"}, mk(c, c, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
      pulse(P_ODD);
      cyc();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if ((stim != 3'b000) || ep_out || err_illegal || err_timeout) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %b expected none", snap());
         end else begin
            e = exp_q.pop_front();
            if (snap() === e.v) n_pass++;
            else $display("FAIL %s: got %b expected %b", e.name, snap(), e.v);
         end
      end
   end

   initial begin
      idle(2);
      rst = 1'b0;
      chk("reset_state", snap(), 16'd0);

      // add-class: 3 even minor cycles then ep_add
      order_class = 3'b001;
      pulse(P_OV);
      chk("add_busy_accept", {15'd0, busy}, 16'd1);
      idle(3);
      pulse(P_R2);
      idle(3);
      expect_ev("add_stim", mk(3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
      pulse(P_ODD);
      chk("add_gate_run", {13'd0, gate}, 16'd1);
      cyc();
      for (int i = 0; i < 3; i++) begin
         pulse(P_EV);
         cyc();
      end
      expect_ev("add_ep", mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3));
      pulse(P_ADD);
      cyc();
      chk("add_busy_after", {15'd0, busy}, 16'd0);

      // illegal classes; minor_cnt holds from the previous run
      order_class = 3'b011;
      expect_ev("illegal_011", mk(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3));
      pulse(P_OV);
      chk("illegal_busy", {15'd0, busy}, 16'd0);
      order_class = 3'b000;
      expect_ev("illegal_000", mk(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 6'd3));
      pulse(P_OV);
      idle(2);

      // inhibit: r2 under g8 is lost
      order_class = 3'b010;
      pulse(P_OV);
      g8 = 1'b1;
      pulse(P_R2);
      g8 = 1'b0;
      pulse(P_ODD);
      idle(2);
      pulse(P_R2);
      expect_ev("inhibit_stim", mk(3'b010, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0));
      pulse(P_ODD);
      cyc();
      expect_ev("inhibit_ep", mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0));
      pulse(P_MUL);
      idle(2);

      // orders offered mid-RUN are ignored
      start(3'b100, "busy");
      pulse(P_EV);
      order_class = 3'b001;
      pulse(P_OV);
      order_class = 3'b111;
      pulse(P_OV);
      expect_ev("busy_ep", mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1));
      pulse(P_SH);
      idle(3);
      chk("busy_no_latch", {15'd0, busy}, 16'd0);

      // watchdog: multiply never ends, stray end pulses ignored
      start(3'b010, "wd");
      pulse(P_EV);
      pulse(P_EV);
      pulse(P_ADD | P_SH);
      pulse(P_EV);
      chk("wd_cnt3", {10'd0, minor_cnt}, 16'd3);
      expect_ev("wd_timeout", mk(3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4));
      pulse(P_EV);
      pulse(P_MUL);
      idle(3);
      chk("wd_idle", {gate, ep_out, busy, 11'd0}, 16'd0);

      // boundary: end pulse coincident with reaching the limit wins
      start(3'b100, "bnd");
      for (int i = 0; i < 3; i++) pulse(P_EV);
      expect_ev("bnd_ep", mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd4));
      pulse(P_EV | P_SH);
      idle(3);

      // reset mid-RUN, then a fresh order
      start(3'b001, "rst");
      pulse(P_EV);
      pulse(P_EV);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("rst_mid_run", snap(), 16'd0);
      start(3'b001, "fresh");
      expect_ev("fresh_ep", mk(3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0));
      pulse(P_ADD);
      idle(2);
      chk("fresh_busy_after", {15'd0, busy}, 16'd0);

      idle(3);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL sb_empty: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
